mem_copy_engine: RTL

- Initiator-side memory mover for the simple single-port word RAM bus used by `mem16k` and other memory responders.
- Accepts one command at a time (block copy or constant fill), then drives `addr_o`, `write_en_o` and `data_o` and samples `data_i`, exactly as a generated `mod_main` does.
- Sits beside the compiled design, which hands it bulk memory work and waits for `done_o`.

---
 rtl/mem_bus_pkg.sv | 32 +++
 rtl/mem_copy_engine.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/mem_bus_pkg.sv
// Shared definitions for initiators on the single-port word RAM bus.
// Word geometry, op encodings, FSM states and the region checker.
package mem_bus_pkg;

  localparam int unsigned WORD_BYTES        = 4;
  localparam int unsigned MEM_BYTES_DEFAULT = 65536;

  localparam logic OP_COPY = 1'b0;
  localparam logic OP_FILL = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_FILL,
    ST_RD,
    ST_LAT,
    ST_WR,
    ST_FIN
  } state_e;

  // Word-aligned and base + 4*words within limit; 35-bit sum cannot wrap.
  function automatic logic region_ok(
    input logic [31:0] base,
    input logic [31:0] words,
    input logic [34:0] limit
  );
    logic [34:0] end_b;
    end_b = {3'b000, base} + {1'b0, words, 2'b00};
    return (base[1:0] == 2'b00) && (end_b <= limit);
  endfunction

endpackage

// File: rtl/mem_copy_engine.sv
// Block copy / constant fill initiator for the word RAM bus.
// One command at a time: capture, check, then one word per FILL or RD/LAT/WR.
module mem_copy_engine
  import mem_bus_pkg::*;
#(
  parameter int unsigned LEN_W     = 16,
  parameter int unsigned MEM_BYTES = MEM_BYTES_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             op_i,
  input  logic [31:0]      src_i,
  input  logic [31:0]      dst_i,
  input  logic [LEN_W-1:0] len_i,
  input  logic [31:0]      fill_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic [31:0]      addr_o,
  output logic             write_en_o,
  output logic [31:0]      data_o,
  input  logic [31:0]      data_i
);

  localparam logic [34:0] LIMIT = 35'(MEM_BYTES);
  localparam logic [31:0] STEP  = 32'(WORD_BYTES);

  state_e           state_q, state_d;
  logic             op_q, op_d;
  logic [31:0]      src_q, src_d;
  logic [31:0]      dst_q, dst_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic [31:0]      fill_q, fill_d;
  logic [31:0]      buf_q, buf_d;
  logic             err_q, err_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      data_q, data_d;
  logic             we_q, we_d;

  logic [31:0] len32;
  logic        cmd_ok;
  logic        last;

  assign len32  = 32'(rem_q);
  assign last   = (rem_q == LEN_W'(1));
  assign cmd_ok = region_ok(dst_q, len32, LIMIT) &&
                  ((op_q == OP_FILL) || region_ok(src_q, len32, LIMIT));

  // Bus outputs are registered: each branch loads what the next state drives.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    src_d   = src_q;
    dst_d   = dst_q;
    rem_d   = rem_q;
    fill_d  = fill_q;
    buf_d   = buf_q;
    err_d   = err_q;
    addr_d  = addr_q;
    data_d  = data_q;
    we_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          op_d    = op_i;
          src_d   = src_i;
          dst_d   = dst_i;
          rem_d   = len_i;
          fill_d  = fill_i;
          err_d   = 1'b0;
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (!cmd_ok) begin
          err_d   = 1'b1;
          state_d = ST_FIN;
        end else if (rem_q == '0) begin
          state_d = ST_FIN;
        end else if (op_q == OP_FILL) begin
          addr_d  = dst_q;
          data_d  = fill_q;
          we_d    = 1'b1;
          state_d = ST_FILL;
        end else begin
          addr_d  = src_q;
          state_d = ST_RD;
        end
      end
      ST_FILL: begin
        dst_d = dst_q + STEP;
        rem_d = rem_q - LEN_W'(1);
        if (last) begin
          state_d = ST_FIN;
        end else begin
          addr_d = dst_q + STEP;
          we_d   = 1'b1;
        end
      end
      ST_RD: begin
        state_d = ST_LAT;
      end
      ST_LAT: begin
        buf_d   = data_i;
        addr_d  = dst_q;
        data_d  = data_i;
        we_d    = 1'b1;
        state_d = ST_WR;
      end
      ST_WR: begin
        src_d = src_q + STEP;
        dst_d = dst_q + STEP;
        rem_d = rem_q - LEN_W'(1);
        if (last) begin
          state_d = ST_FIN;
        end else begin
          addr_d  = src_q + STEP;
          state_d = ST_RD;
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_q    <= OP_COPY;
      src_q   <= '0;
      dst_q   <= '0;
      rem_q   <= '0;
      fill_q  <= '0;
      buf_q   <= '0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      rem_q   <= rem_d;
      fill_q  <= fill_d;
      buf_q   <= buf_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      we_q    <= we_d;
    end
  end

  assign busy_o     = (state_q != ST_IDLE) && (state_q != ST_FIN);
  assign done_o     = (state_q == ST_FIN);
  assign err_o      = (state_q == ST_FIN) && err_q;
  assign addr_o     = addr_q;
  assign data_o     = data_q;
  assign write_en_o = we_q;

endmodule
